// File: rtl/signed_seq_divider_if.sv
// Request/response bundle for the signed sequential divider.
interface signed_seq_divider_if #(
  parameter int unsigned DW_N = 15,
  parameter int unsigned DW_D = 8
);
  logic            start;
  logic [DW_N-1:0] dividend;
  logic [DW_D-1:0] divisor;
  logic            busy;
  logic            done;
  logic [DW_D-1:0] quotient;
  logic [DW_D-1:0] remainder;
  logic            ovf;
  logic            div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, ovf, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, ovf, div_zero
  );
endinterface

// File: rtl/signed_seq_divider.sv
// Restoring shift-subtract signed divider: 15-bit dividend / 8-bit divisor,
// one quotient bit per cycle, saturated 8-bit quotient, start/busy/done handshake.
module signed_seq_divider (
  input  logic                clk,
  input  logic                n_rst,
  signed_seq_divider_if.slave bus
);
  localparam int unsigned DW_N = 15;
  localparam int unsigned DW_D = 8;
  localparam int unsigned CW   = 4;

  localparam logic signed [DW_N:0] Q_MAX = (DW_N+1)'(127);
  localparam logic signed [DW_N:0] Q_MIN = ~Q_MAX;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [DW_N-1:0] dvd, dvd_n;
  logic [DW_D-1:0] dvs, dvs_n;
  logic [DW_D-1:0] rem, rem_n;
  logic            sign_q, sign_q_n;
  logic            sign_r, sign_r_n;
  logic            zero, zero_n;
  logic            busy, busy_n;
  logic            done, done_n;
  logic [DW_D-1:0] quotient, quotient_n;
  logic [DW_D-1:0] remainder, remainder_n;
  logic            ovf, ovf_n;
  logic            div_zero, div_zero_n;

  logic [DW_D:0]          shifted;
  logic                   ge;
  logic signed [DW_N:0]   q_signed;

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      zero      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      dvd       <= dvd_n;
      dvs       <= dvs_n;
      rem       <= rem_n;
      sign_q    <= sign_q_n;
      sign_r    <= sign_r_n;
      zero      <= zero_n;
      busy      <= busy_n;
      done      <= done_n;
      quotient  <= quotient_n;
      remainder <= remainder_n;
      ovf       <= ovf_n;
      div_zero  <= div_zero_n;
    end
  end

  // Next-state, iteration step and sign/saturation fix-up.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    dvd_n       = dvd;
    dvs_n       = dvs;
    rem_n       = rem;
    sign_q_n    = sign_q;
    sign_r_n    = sign_r;
    zero_n      = zero;
    busy_n      = busy;
    done_n      = 1'b0;
    quotient_n  = quotient;
    remainder_n = remainder;
    ovf_n       = ovf;
    div_zero_n  = div_zero;

    // Dividend register doubles as quotient shift register: MSB out, quotient bit in.
    shifted  = {rem, dvd[DW_N-1]};
    ge       = (shifted >= {1'b0, dvs});
    q_signed = sign_q ? -$signed({1'b0, dvd}) : $signed({1'b0, dvd});

    unique case (state)
      IDLE: begin
        busy_n = bus.start;
        if (bus.start) begin
          dvd_n    = bus.dividend[DW_N-1] ? (~bus.dividend + DW_N'(1)) : bus.dividend;
          dvs_n    = bus.divisor[DW_D-1]  ? (~bus.divisor + DW_D'(1))  : bus.divisor;
          rem_n    = '0;
          sign_q_n = bus.dividend[DW_N-1] ^ bus.divisor[DW_D-1];
          sign_r_n = bus.dividend[DW_N-1];
          zero_n   = (bus.divisor == '0);
          cnt_n    = CW'(DW_N - 1);
          state_n  = (bus.divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        busy_n = 1'b1;
        rem_n  = ge ? DW_D'(shifted - {1'b0, dvs}) : DW_D'(shifted);
        dvd_n  = {dvd[DW_N-2:0], ge};
        cnt_n  = cnt - CW'(1);
        if (cnt == '0) begin
          state_n = FIX;
        end
      end
      FIX: begin
        busy_n  = 1'b1;
        done_n  = 1'b1;
        state_n = IDLE;
        if (zero) begin
          quotient_n  = '0;
          remainder_n = '0;
          ovf_n       = 1'b0;
          div_zero_n  = 1'b1;
        end else begin
          div_zero_n  = 1'b0;
          remainder_n = sign_r ? (~rem + DW_D'(1)) : rem;
          if (q_signed > Q_MAX) begin
            quotient_n = Q_MAX[DW_D-1:0];
            ovf_n      = 1'b1;
          end else if (q_signed < Q_MIN) begin
            quotient_n = Q_MIN[DW_D-1:0];
            ovf_n      = 1'b1;
          end else begin
            quotient_n = q_signed[DW_D-1:0];
            ovf_n      = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.quotient  = quotient;
  assign bus.remainder = remainder;
  assign bus.ovf       = ovf;
  assign bus.div_zero  = div_zero;
endmodule

// File: tb/tb_signed_seq_divider.sv
// Directed bench for signed_seq_divider: latency, signs, saturation,
// divide-by-zero, back-to-back sweep and mid-operation reset.
module tb_signed_seq_divider;
  logic clk = 1'b0;
  logic n_rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  signed_seq_divider_if bus ();

  signed_seq_divider dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Directed vectors: dividend, divisor, quotient, remainder, ovf.
  int v_a[7] = '{-56, 100, -100, 100, -1024, -16384, 16383};
  int v_b[7] = '{-8,  7,   7,    -7,  8,     -128,   1};
  int v_q[7] = '{7,   14,  -14,  -14, -128,  127,    127};
  int v_r[7] = '{0,   2,   -2,   2,   0,     0,      0};
  int v_o[7] = '{0,   0,   0,    0,   0,     1,      1};

  // Hard stop if something hangs despite the bounded waits.
  initial begin
    #500000;
    $display("FAIL watchdog: run still active at %0t, limit 500000", $time);
    $fatal(1, "watchdog expired");
  end

  // Issue one operation, scramble inputs after acceptance, wait for done (bounded).
  task automatic do_op(input int a, input int b, output int lat,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic ov, output logic dz);
    bus.dividend = 15'(a);
    bus.divisor  = 8'(b);
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = 15'h2aaa;
    bus.divisor  = 8'h55;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    q  = bus.quotient;
    r  = bus.remainder;
    ov = bus.ovf;
    dz = bus.div_zero;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    #3;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.quotient !== 8'h00) begin n_bad++; $display("FAIL reset_quotient: got %h want 00", bus.quotient); end
    n_cmp++; if (bus.remainder !== 8'h00) begin n_bad++; $display("FAIL reset_remainder: got %h want 00", bus.remainder); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
    n_cmp++; if (bus.div_zero !== 1'b0) begin n_bad++; $display("FAIL reset_div_zero: got %b want 0", bus.div_zero); end
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_directed();
    int lat;
    logic [7:0] q, r;
    logic ov, dz;
    for (int i = 0; i < 7; i++) begin
      do_op(v_a[i], v_b[i], lat, q, r, ov, dz);
      n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want 16", i, lat); end
      n_cmp++; if (q !== 8'(v_q[i])) begin n_bad++; $display("FAIL dir%0d_quotient: got %0d want %0d", i, $signed(q), v_q[i]); end
      n_cmp++; if (r !== 8'(v_r[i])) begin n_bad++; $display("FAIL dir%0d_remainder: got %0d want %0d", i, $signed(r), v_r[i]); end
      n_cmp++; if (ov !== 1'(v_o[i])) begin n_bad++; $display("FAIL dir%0d_ovf: got %b want %0d", i, ov, v_o[i]); end
      n_cmp++; if (dz !== 1'b0) begin n_bad++; $display("FAIL dir%0d_div_zero: got %b want 0", i, dz); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL dir%0d_busy_done_cycle: got %b want 1", i, bus.busy); end
      @(posedge clk); #1;
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL dir%0d_done_pulse: got %b want 0", i, bus.done); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL dir%0d_busy_after: got %b want 0", i, bus.busy); end
      n_cmp++; if (bus.quotient !== 8'(v_q[i])) begin n_bad++; $display("FAIL dir%0d_quotient_hold: got %0d want %0d", i, $signed(bus.quotient), v_q[i]); end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic [7:0] q, r;
    logic ov, dz;
    do_op(55, 0, lat, q, r, ov, dz);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL dz_latency: got %0d want 1", lat); end
    n_cmp++; if (dz !== 1'b1) begin n_bad++; $display("FAIL dz_flag: got %b want 1", dz); end
    n_cmp++; if (q !== 8'h00) begin n_bad++; $display("FAIL dz_quotient: got %0d want 0", $signed(q)); end
    n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL dz_remainder: got %0d want 0", $signed(r)); end
    n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL dz_ovf: got %b want 0", ov); end
    @(posedge clk); #1;
    n_cmp++; if (bus.div_zero !== 1'b1) begin n_bad++; $display("FAIL dz_hold: got %b want 1", bus.div_zero); end
    do_op(100, 7, lat, q, r, ov, dz);
    n_cmp++; if (dz !== 1'b0) begin n_bad++; $display("FAIL dz_cleared: got %b want 0", dz); end
    n_cmp++; if (q !== 8'd14) begin n_bad++; $display("FAIL dz_next_quotient: got %0d want 14", $signed(q)); end
    n_cmp++; if (r !== 8'd2) begin n_bad++; $display("FAIL dz_next_remainder: got %0d want 2", $signed(r)); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int a, b, e, lat;
    bus.start = 1'b1;
    for (int k = 0; k < 256; k++) begin
      a = k - 128;
      b = (a == -128) ? 127 : -a;
      if (b == 0) b = 1;
      e = a * b;
      bus.dividend = 15'(e);
      bus.divisor  = 8'(b);
      @(posedge clk); #1;
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b%0d_busy: got %b want 1", k, bus.busy); end
      lat = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL b2b%0d_latency: got %0d want 16", k, lat); end
      n_cmp++; if (bus.quotient !== 8'(a)) begin n_bad++; $display("FAIL b2b%0d_quotient: %0d/%0d got %0d want %0d", k, e, b, $signed(bus.quotient), a); end
      n_cmp++; if (bus.remainder !== 8'h00) begin n_bad++; $display("FAIL b2b%0d_remainder: got %0d want 0", k, $signed(bus.remainder)); end
      n_cmp++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL b2b%0d_ovf: got %b want 0", k, bus.ovf); end
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_end_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid_calc();
    int lat, n_done;
    logic [7:0] q, r;
    logic ov, dz;
    do_op(100, 7, lat, q, r, ov, dz);
    @(posedge clk); #1;
    bus.dividend = 15'(100);
    bus.divisor  = 8'(7);
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.quotient !== 8'h00) begin n_bad++; $display("FAIL rst_mid_quotient: got %0d want 0", $signed(bus.quotient)); end
    n_cmp++; if (bus.remainder !== 8'h00) begin n_bad++; $display("FAIL rst_mid_remainder: got %0d want 0", $signed(bus.remainder)); end
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) n_done++;
    end
    n_cmp++; if (n_done !== 0) begin n_bad++; $display("FAIL rst_mid_no_done: got %0d done pulses want 0", n_done); end
    do_op(-100, 7, lat, q, r, ov, dz);
    n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL rst_after_latency: got %0d want 16", lat); end
    n_cmp++; if (q !== 8'(-14)) begin n_bad++; $display("FAIL rst_after_quotient: got %0d want -14", $signed(q)); end
    n_cmp++; if (r !== 8'(-2)) begin n_bad++; $display("FAIL rst_after_remainder: got %0d want -2", $signed(r)); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_calc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
